// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction, one response out.
// Optional watchdog output o_timeout is built when AXIML_TIMEOUT_EN is defined.
module axi_lite_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    i_axi_clk,
    input  logic                    i_axi_rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
    input  logic [STROBE_WIDTH-1:0] i_cmd_wstrb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]              o_rsp_resp,
    output logic                    o_awvalid,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    input  logic                    i_awready,
    output logic                    o_wvalid,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [STROBE_WIDTH-1:0] o_wstrb,
    input  logic                    i_wready,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    input  logic [1:0]              i_bresp,
    output logic                    o_arvalid,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    input  logic                    i_arready,
    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [1:0]              i_rresp,
`ifdef AXIML_TIMEOUT_EN
    output logic                    o_timeout,
`endif
    input  logic [DATA_WIDTH-1:0]   i_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STROBE_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    cmd_accept;
    logic                    aw_done;
    logic                    w_done;

`ifdef AXIML_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        cmd_accept  = 1'b0;
        // A channel counts as done once its valid has already dropped or its ready is seen now.
        aw_done     = !awvalid_q || i_awready;
        w_done      = !wvalid_q || i_wready;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_ready_q && i_cmd_valid) begin
                    cmd_accept  = 1'b1;
                    cmd_ready_d = 1'b0;
                    addr_d      = i_cmd_addr;
                    if (i_cmd_wr) begin
                        wdata_d   = i_cmd_wdata;
                        wstrb_d   = i_cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR: begin
                if (awvalid_q && i_awready) awvalid_d = 1'b0;
                if (wvalid_q && i_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (i_bvalid) begin
                    bready_d    = 1'b0;
                    resp_d      = i_bresp;
                    rdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_ADDR: begin
                if (i_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (i_rvalid) begin
                    rready_d    = 1'b0;
                    rdata_d     = i_rdata;
                    resp_d      = i_rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef AXIML_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (cmd_accept) begin
            cnt_d = '0;
        end else if (state_q != IDLE && state_q != RSP && cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) timeout_d = 1'b1;
`endif
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
`ifdef AXIML_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
`ifdef AXIML_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_resp  = resp_q;
    assign o_awvalid   = awvalid_q;
    assign o_awaddr    = addr_q;
    assign o_wvalid    = wvalid_q;
    assign o_wdata     = wdata_q;
    assign o_wstrb     = wstrb_q;
    assign o_bready    = bready_q;
    assign o_arvalid   = arvalid_q;
    assign o_araddr    = addr_q;
    assign o_rready    = rready_q;
`ifdef AXIML_TIMEOUT_EN
    assign o_timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: reactive AXI-Lite slave model plus a response scoreboard.
// Define AXIML_TIMEOUT_EN to also exercise the watchdog output.
module tb_axi_lite_master;

`ifdef AXIML_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 1024;
`endif

    logic        clk;
    logic        i_axi_rst;
    logic        i_cmd_valid, i_cmd_wr, i_rsp_ready;
    logic [31:0] i_cmd_addr, i_cmd_wdata;
    logic [3:0]  i_cmd_wstrb;
    logic        o_cmd_ready, o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic        o_awvalid, i_awready, o_wvalid, i_wready;
    logic [31:0] o_awaddr, o_wdata, o_araddr;
    logic [3:0]  o_wstrb;
    logic        i_bvalid, o_bready, o_arvalid, i_arready, i_rvalid, o_rready;
    logic [1:0]  i_bresp, i_rresp;
    logic [31:0] i_rdata;
`ifdef AXIML_TIMEOUT_EN
    logic        o_timeout;
`endif

    axi_lite_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .STROBE_WIDTH  (4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_axi_clk  (clk),
        .i_axi_rst  (i_axi_rst),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_wr   (i_cmd_wr),
        .i_cmd_addr (i_cmd_addr),
        .i_cmd_wdata(i_cmd_wdata),
        .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_resp (o_rsp_resp),
        .o_awvalid  (o_awvalid),
        .o_awaddr   (o_awaddr),
        .i_awready  (i_awready),
        .o_wvalid   (o_wvalid),
        .o_wdata    (o_wdata),
        .o_wstrb    (o_wstrb),
        .i_wready   (i_wready),
        .i_bvalid   (i_bvalid),
        .o_bready   (o_bready),
        .i_bresp    (i_bresp),
        .o_arvalid  (o_arvalid),
        .o_araddr   (o_araddr),
        .i_arready  (i_arready),
        .i_rvalid   (i_rvalid),
        .o_rready   (o_rready),
        .i_rresp    (i_rresp),
`ifdef AXIML_TIMEOUT_EN
        .o_timeout  (o_timeout),
`endif
        .i_rdata    (i_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Slave model knobs and bookkeeping
    int          aw_lat = 0, w_lat = 0, ar_lat = 0;
    bit          rdy_always = 0, b_stall = 0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = '0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, proto_err = 0;
    logic [31:0] last_aw, last_wd, last_ar;
    logic [3:0]  last_ws;

    // The slave acts on falling edges; the DUT samples its inputs on the next rising edge.
    initial begin
        int          aw_wait, w_wait, ar_wait;
        bit          aw_fire, w_fire, ar_fire, b_fire, r_fire;
        bit          aw_done, w_done, ar_done, aw_pend, w_pend, ar_pend;
        logic [31:0] p_aw, p_wd, p_ar;
        logic [3:0]  p_ws;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        {aw_fire, w_fire, ar_fire, b_fire, r_fire} = '0;
        {aw_done, w_done, ar_done, aw_pend, w_pend, ar_pend} = '0;
        p_aw = '0; p_wd = '0; p_ar = '0; p_ws = '0;
        forever begin
            @(negedge clk);
            if (!i_axi_rst) begin
                {i_awready, i_wready, i_arready, i_bvalid, i_rvalid} = '0;
                {aw_fire, w_fire, ar_fire, b_fire, r_fire} = '0;
                {aw_done, w_done, ar_done, aw_pend, w_pend, ar_pend} = '0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
            end else begin
                if (aw_pend && (o_awvalid !== 1'b1 || o_awaddr !== p_aw)) proto_err++;
                if (w_pend && (o_wvalid !== 1'b1 || {o_wdata, o_wstrb} !== {p_wd, p_ws})) proto_err++;
                if (ar_pend && (o_arvalid !== 1'b1 || o_araddr !== p_ar)) proto_err++;
                if (aw_fire) begin aw_hs++; aw_done = 1; end
                if (w_fire)  begin w_hs++;  w_done  = 1; end
                if (ar_fire) begin ar_hs++; ar_done = 1; end
                if (b_fire)  begin b_hs++;  i_bvalid = 1'b0; end
                if (r_fire)  begin r_hs++;  i_rvalid = 1'b0; end
                if (aw_done && w_done && !i_bvalid && !b_stall) begin
                    i_bvalid = 1'b1; i_bresp = s_bresp; aw_done = 0; w_done = 0;
                end
                if (ar_done && !i_rvalid) begin
                    i_rvalid = 1'b1; i_rdata = s_rdata; i_rresp = s_rresp; ar_done = 0;
                end
                i_awready = rdy_always || (o_awvalid && aw_wait >= aw_lat);
                i_wready  = rdy_always || (o_wvalid && w_wait >= w_lat);
                i_arready = rdy_always || (o_arvalid && ar_wait >= ar_lat);
                if (o_awvalid && !i_awready) aw_wait++;
                if (o_wvalid && !i_wready)   w_wait++;
                if (o_arvalid && !i_arready) ar_wait++;
                aw_fire = o_awvalid && i_awready;
                w_fire  = o_wvalid && i_wready;
                ar_fire = o_arvalid && i_arready;
                b_fire  = i_bvalid && o_bready;
                r_fire  = i_rvalid && o_rready;
                if (aw_fire) begin aw_wait = 0; last_aw = o_awaddr; end
                if (w_fire)  begin w_wait = 0;  last_wd = o_wdata; last_ws = o_wstrb; end
                if (ar_fire) begin ar_wait = 0; last_ar = o_araddr; end
                aw_pend = o_awvalid && !i_awready; p_aw = o_awaddr;
                w_pend  = o_wvalid && !i_wready;   p_wd = o_wdata; p_ws = o_wstrb;
                ar_pend = o_arvalid && !i_arready; p_ar = o_araddr;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {57'd0, o_cmd_ready, o_awvalid, o_wvalid, o_bready,
                               o_arvalid, o_rready, o_rsp_valid}, 64'd0);
        check({tag, "_rsp"}, {30'd0, o_rsp_resp, o_rsp_rdata}, 64'd0);
        check({tag, "_addr"}, {o_awaddr, o_araddr}, 64'd0);
        check({tag, "_wdata"}, {28'd0, o_wstrb, o_wdata}, 64'd0);
    endtask

    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, output int c0);
        int t;
        i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_wdata = wdata; i_cmd_wstrb = strb;
        i_cmd_valid = 1'b1;
        t = 0;
        while (!o_cmd_ready && t < 50) begin tick(); t++; end
        check("cmd_accept", {63'd0, o_cmd_ready}, 64'd1);
        c0 = cyc;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [31:0] exp_rdata,
                           input logic [1:0] exp_resp, input int hold, input bit chk_lat,
                           input bit chk_wfirst);
        int   c0, t, b_aw, b_w, b_ar, b_b, b_r;
        exp_t e;
        e.rdata = exp_rdata; e.resp = exp_resp;
        sb.push_back(e);
        b_aw = aw_hs; b_w = w_hs; b_ar = ar_hs; b_b = b_hs; b_r = r_hs;
        issue_cmd(wr, addr, wdata, strb, c0);
        t = 0;
        while (!o_rsp_valid && t < 100) begin
            if (chk_wfirst && cyc == c0 + 2) begin
                check("wfirst_wvalid", {63'd0, o_wvalid}, 64'd0);
                check("wfirst_awvalid", {63'd0, o_awvalid}, 64'd1);
            end
            tick(); t++;
        end
        check("rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
        if (chk_lat) check("latency", 64'(cyc - c0), 64'd3);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {63'd0, o_rsp_valid}, 64'd1);
            check("hold_data", {30'd0, o_rsp_resp, o_rsp_rdata}, {30'd0, sb[0].resp, sb[0].rdata});
            check("hold_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
            tick();
        end
        i_rsp_ready = 1'b1;
        e = sb.pop_front();
        check("rsp_rdata", {32'd0, o_rsp_rdata}, {32'd0, e.rdata});
        check("rsp_resp", {62'd0, o_rsp_resp}, {62'd0, e.resp});
        tick();
        i_rsp_ready = 1'b0;
        check("rsp_drop", {63'd0, o_rsp_valid}, 64'd0);
        if (wr) begin
            check("aw_count", 64'(aw_hs - b_aw), 64'd1);
            check("w_count", 64'(w_hs - b_w), 64'd1);
            check("b_count", 64'(b_hs - b_b), 64'd1);
            check("ar_count_wr", 64'(ar_hs - b_ar), 64'd0);
            check("awaddr", {32'd0, last_aw}, {32'd0, addr});
            check("wdata", {28'd0, last_ws, last_wd}, {28'd0, strb, wdata});
        end else begin
            check("ar_count", 64'(ar_hs - b_ar), 64'd1);
            check("r_count", 64'(r_hs - b_r), 64'd1);
            check("aw_count_rd", 64'(aw_hs - b_aw), 64'd0);
            check("araddr", {32'd0, last_ar}, {32'd0, addr});
        end
    endtask

    initial begin
        int c0, t;
        i_axi_rst = 1'b0; i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_rsp_ready = 1'b0;
        i_cmd_addr = '0; i_cmd_wdata = '0; i_cmd_wstrb = '0;
        i_awready = 1'b0; i_wready = 1'b0; i_arready = 1'b0;
        i_bvalid = 1'b0; i_rvalid = 1'b0; i_bresp = '0; i_rresp = '0; i_rdata = '0;
        tick(); tick();
        check_reset_outputs("reset");
`ifdef AXIML_TIMEOUT_EN
        check("reset_timeout", {63'd0, o_timeout}, 64'd0);
`endif
        i_axi_rst = 1'b1;
        tick(); tick();
        check("idle_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);

        // Zero-wait slave with readies held high ahead of the valids
        rdy_always = 1;
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 0, 1'b1, 1'b0);
        rdy_always = 0;

        s_rdata = 32'h12345678; s_rresp = 2'b00;
        run_txn(1'b0, 32'h04, 32'h0, 4'h0, 32'h12345678, 2'b00, 0, 1'b1, 1'b0);

        // W accepted 4 cycles ahead of AW; write response must clear the earlier read data
        aw_lat = 4; s_bresp = 2'b01;
        run_txn(1'b1, 32'h20, 32'hA5A55A5A, 4'h5, 32'h0, 2'b01, 0, 1'b0, 1'b1);
        aw_lat = 0; s_bresp = 2'b00;

        // AW accepted before W
        w_lat = 2;
        run_txn(1'b1, 32'h24, 32'h0000BEEF, 4'h3, 32'h0, 2'b00, 0, 1'b0, 1'b0);
        w_lat = 0;

        s_rdata = 32'hCAFEF00D; s_rresp = 2'b10;
        run_txn(1'b0, 32'h08, 32'h0, 4'h0, 32'hCAFEF00D, 2'b10, 5, 1'b0, 1'b0);

        // Reset while waiting for B: no response may survive
        b_stall = 1;
        issue_cmd(1'b1, 32'h30, 32'h11223344, 4'hF, c0);
        t = 0;
        while (!o_bready && t < 20) begin tick(); t++; end
        check("reached_wr_resp", {63'd0, o_bready}, 64'd1);
        i_axi_rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick(); tick();
        i_axi_rst = 1'b1; b_stall = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_stale_rsp", {63'd0, o_rsp_valid}, 64'd0);
        end
        check("post_reset_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
        s_rdata = 32'h0BADCAFE; s_rresp = 2'b00;
        run_txn(1'b0, 32'h0C, 32'h0, 4'h0, 32'h0BADCAFE, 2'b00, 0, 1'b1, 1'b0);

`ifdef AXIML_TIMEOUT_EN
        // Slave never accepts AR; watchdog fires but the read stays posted
        ar_lat = 100000;
        issue_cmd(1'b0, 32'h40, 32'h0, 4'h0, c0);
        for (int k = 1; k < 8; k++) tick();
        check("timeout_before", {63'd0, o_timeout}, 64'd0);
        tick();
        check("timeout_set", {63'd0, o_timeout}, 64'd1);
        check("timeout_arvalid", {63'd0, o_arvalid}, 64'd1);
        for (int i = 0; i < 4; i++) tick();
        check("timeout_sticky", {62'd0, o_timeout, o_arvalid}, 64'd3);
        i_axi_rst = 1'b0;
        #1;
        check("timeout_reset", {63'd0, o_timeout}, 64'd0);
        tick();
        i_axi_rst = 1'b1; ar_lat = 0;
        tick(); tick();
`endif

        check("protocol_errors", 64'(proto_err), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into AXI4-Lite register reads and writes.
- It is the driving end for the dtw_accel AXI-Lite slave port. Targets are bench sequencers or on-chip control logic that configure the accelerator and poll its status.
- It accepts one command, runs exactly one AXI transaction, then returns one response.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width
STROBE_WIDTH, DATA_WIDTH/8, write strobe width
TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
i_axi_clk  input  1  single clock for all logic
i_axi_rst  input  1  asynchronous, active-low reset
i_cmd_valid  input  1  command valid
o_cmd_ready  output  1  command accepted when high together with i_cmd_valid
i_cmd_wr  input  1  1 = write, 0 = read
i_cmd_addr  input  ADDR_WIDTH  target address
i_cmd_wdata  input  DATA_WIDTH  write data
i_cmd_wstrb  input  STROBE_WIDTH  write byte strobes
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  response consumed
o_rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
o_rsp_resp  output  2  BRESP or RRESP of the transaction
o_awvalid  output  1  AW valid
o_awaddr  output  ADDR_WIDTH  AW address
i_awready  input  1  AW ready
o_wvalid  output  1  W valid
o_wdata  output  DATA_WIDTH  W data
o_wstrb  output  STROBE_WIDTH  W strobes
i_wready  input  1  W ready
i_bvalid  input  1  B valid
o_bready  output  1  B ready
i_bresp  input  2  B response
o_arvalid  output  1  AR valid
o_araddr  output  ADDR_WIDTH  AR address
i_arready  input  1  AR ready
i_rvalid  input  1  R valid
o_rready  output  1  R ready
i_rresp  input  2  R response
i_rdata  input  DATA_WIDTH  R data

Behaviour:
- Reset (i_axi_rst low, asynchronous): state = IDLE; all valid/ready outputs 0; o_rsp_rdata, o_rsp_resp, address/data/strobe outputs 0.
- Reset mid-transaction: abandons the transaction immediately; no response is produced.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - o_cmd_ready = 1 (registered, high only in IDLE).
  - On i_cmd_valid, latch the command.
  - Write: next state WR; o_awvalid = o_wvalid = 1 on the next cycle.
  - Read: next state RD_ADDR; o_arvalid = 1 on the next cycle.
- WR:
  - AW and W are independent. Each valid drops the cycle after its own ready is sampled high.
  - Address, data and strobes are held stable while the corresponding valid is high.
  - Exit to WR_RESP only after both AW and W have been accepted, in either order or in the same cycle.
- WR_RESP:
  - o_bready = 1.
  - On i_bvalid: capture i_bresp and set o_rsp_rdata = 0; go to RSP.
- RD_ADDR: on i_arready, o_arvalid drops; go to RD_DATA.
- RD_DATA:
  - o_rready = 1.
  - On i_rvalid: capture i_rdata and i_rresp; go to RSP.
- RSP:
  - o_rsp_valid = 1, with data and response held until i_rsp_ready.
  - Then return to IDLE.
  - A new command is accepted no earlier than the cycle after the response is consumed.
- Ready-before-valid from the slave is legal. A ready sampled while the corresponding valid is low is ignored.
- Minimum latency with a zero-wait slave:
  - Write: command accept to o_rsp_valid = 3 cycles.
  - Read: command accept to o_rsp_valid = 3 cycles.
- Valids never deassert before their handshake completes (AXI rule).

Optional Feature:
- Macro: AXIML_TIMEOUT_EN.
- When defined:
  - Adds output o_timeout (1 bit).
  - A cycle counter clears on each command accept and increments in every non-IDLE, non-RSP state.
  - When the counter reaches TIMEOUT_CYCLES, o_timeout is set and is sticky until reset.
  - The AXI transaction is not aborted; all valids remain asserted.
- When undefined: no counter and no o_timeout port. Behaviour is otherwise identical.

Test Plan:
- Zero-wait slave, write addr 0x10, data 0xDEADBEEF, strb 0xF -> AW and W each handshake once with the latched values; response resp = 0 and rdata = 0 at 3 cycles.
- Read addr 0x04, slave returns 0x12345678 with OKAY -> o_rsp_rdata = 0x12345678, o_rsp_resp = 0.
- Write where the slave accepts W 4 cycles before AW -> o_wvalid drops after its handshake, o_awvalid stays high until accepted; exactly one B handshake.
- Read with i_rresp = 2'b10 and i_rsp_ready held low for 5 cycles -> o_rsp_valid and data are held stable; o_cmd_ready stays 0 until the response is consumed.
- i_axi_rst asserted during WR_RESP -> all outputs 0 immediately; a new command is accepted after release with no stale response.
- AXIML_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and a slave that never asserts i_arready -> o_timeout rises on the 8th wait cycle and o_arvalid stays 1.
